// File: rtl/buffer_frame_reader.sv
// buffer_frame_reader
// Read-side sequencer for the double buffer. Once a complete frame is
// readable on port B, it reads words 0..ADDRESS_DEPTH-1 one at a time and
// hands each word to the SPI output module over a valid/ready handshake.
// After the last word has been accepted and the output module reports that
// transmission has finished, it pulses buf_swap so the banks exchange. It then
// idles for GUARD_CYCLES before it looks at buf_valid again.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   buf_valid       a filled frame is readable (sampled only when idle)
//   buf_swap        one-cycle bank swap pulse
//   rd_en, adb      port B read strobe and address
//   buf_dout        port B read data, valid READ_LATENCY cycles after rd_en
//   out_data        registered word for the output module (bank 0 in LSBs)
//   out_valid       out_data valid; held until out_ready is seen
//   out_ready       output module accepts the word
//   out_new_image   first word of the frame
//   out_new_column  first word of each column group
//   tx_finish       output module finished shifting the last word
//   busy            sequencer is not idle
module buffer_frame_reader #(
  parameter int BANK_COUNT       = 3,
  parameter int ADDRESS_DEPTH    = 480,
  parameter int WORD_WIDTH       = 128,
  parameter int WORDS_PER_COLUMN = 24,
  parameter int READ_LATENCY     = 2,
  parameter int GUARD_CYCLES     = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                buf_valid,
  output logic                                buf_swap,
  output logic                                rd_en,
  output logic [$clog2(ADDRESS_DEPTH)-1:0]    adb,
  input  logic [BANK_COUNT*WORD_WIDTH-1:0]    buf_dout,
  output logic [BANK_COUNT*WORD_WIDTH-1:0]    out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_new_image,
  output logic                                out_new_column,
  input  logic                                tx_finish,
  output logic                                busy
);

  localparam int AW = $clog2(ADDRESS_DEPTH);
  localparam int DW = BANK_COUNT * WORD_WIDTH;
  localparam int LW = $clog2(READ_LATENCY + 1);
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam int CW = $clog2(WORDS_PER_COLUMN + 1);

  localparam logic [AW-1:0] LAST_ADDR = AW'(ADDRESS_DEPTH - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(WORDS_PER_COLUMN - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_WAIT_RD = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
  localparam logic [2:0] S_SWAP    = 3'd5;
  localparam logic [2:0] S_GUARD   = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] adb_q, adb_d;
  logic [CW-1:0] col_q, col_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [GW-1:0] grd_q, grd_d;
  logic [DW-1:0] data_q, data_d;
  logic          img_q, img_d;
  logic          ncol_q, ncol_d;

  always_comb begin
    state_d = state_q;
    adb_d   = adb_q;
    col_d   = col_q;
    lat_d   = lat_q;
    grd_d   = grd_q;
    data_d  = data_q;
    img_d   = img_q;
    ncol_d  = ncol_q;
    case (state_q)
      S_IDLE: begin
        if (buf_valid) begin
          state_d = S_FETCH;
          adb_d   = '0;
          col_d   = '0;
        end
      end
      S_FETCH: begin
        // rd_en is high this cycle; the remaining WAIT_RD cycles are counted
        // down so that capture lands exactly READ_LATENCY cycles later.
        lat_d   = LW'(READ_LATENCY - 1);
        state_d = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        if (lat_q == '0) begin
          data_d  = buf_dout;
          img_d   = (adb_q == '0);
          ncol_d  = (col_q == '0);
          state_d = S_PRESENT;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      S_PRESENT: begin
        if (out_ready) begin
          if (adb_q == LAST_ADDR) begin
            adb_d   = '0;
            col_d   = '0;
            state_d = S_DRAIN;
          end else begin
            adb_d   = adb_q + AW'(1);
            // Column position tracked incrementally instead of adb mod N.
            col_d   = (col_q == LAST_COL) ? '0 : col_q + CW'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DRAIN: begin
        if (tx_finish) state_d = S_SWAP;
      end
      S_SWAP: begin
        grd_d   = GW'(GUARD_CYCLES - 1);
        state_d = S_GUARD;
      end
      S_GUARD: begin
        // buf_valid may still show the pre-swap level here; ignore it.
        if (grd_q == '0) state_d = S_IDLE;
        else             grd_d   = grd_q - GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      adb_q   <= '0;
      col_q   <= '0;
      lat_q   <= '0;
      grd_q   <= '0;
      data_q  <= '0;
      img_q   <= 1'b0;
      ncol_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adb_q   <= adb_d;
      col_q   <= col_d;
      lat_q   <= lat_d;
      grd_q   <= grd_d;
      data_q  <= data_d;
      img_q   <= img_d;
      ncol_q  <= ncol_d;
    end
  end

  assign rd_en          = (state_q == S_FETCH);
  assign out_valid      = (state_q == S_PRESENT);
  assign buf_swap       = (state_q == S_SWAP);
  assign busy           = (state_q != S_IDLE);
  assign adb            = adb_q;
  assign out_data       = data_q;
  // Markers only mean something alongside out_valid.
  assign out_new_image  = img_q & out_valid;
  assign out_new_column = ncol_q & out_valid;

endmodule

// File: tb/tb_buffer_frame_reader.sv
module tb_buffer_frame_reader;

  localparam int DEPTH = 8;
  localparam int DW    = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: READ_LATENCY = 2
  logic          buf_valid, buf_swap, rd_en, out_valid, out_ready;
  logic          out_new_image, out_new_column, tx_finish, busy;
  logic [2:0]    adb;
  logic [DW-1:0] buf_dout, out_data;

  // Instance B: READ_LATENCY = 4
  logic          buf_valid2, buf_swap2, rd_en2, out_valid2, out_ready2;
  logic          out_new_image2, out_new_column2, tx_finish2, busy2;
  logic [2:0]    adb2;
  logic [DW-1:0] buf_dout2, out_data2;

  buffer_frame_reader #(.BANK_COUNT(3), .ADDRESS_DEPTH(DEPTH), .WORD_WIDTH(8),
    .WORDS_PER_COLUMN(4), .READ_LATENCY(2), .GUARD_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .buf_valid(buf_valid), .buf_swap(buf_swap),
    .rd_en(rd_en), .adb(adb), .buf_dout(buf_dout), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_new_image(out_new_image),
    .out_new_column(out_new_column), .tx_finish(tx_finish), .busy(busy));

  buffer_frame_reader #(.BANK_COUNT(3), .ADDRESS_DEPTH(DEPTH), .WORD_WIDTH(8),
    .WORDS_PER_COLUMN(4), .READ_LATENCY(4), .GUARD_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .buf_valid(buf_valid2), .buf_swap(buf_swap2),
    .rd_en(rd_en2), .adb(adb2), .buf_dout(buf_dout2), .out_data(out_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_new_image(out_new_image2),
    .out_new_column(out_new_column2), .tx_finish(tx_finish2), .busy(busy2));

  // Memory model: word appears exactly READ_LATENCY cycles after rd_en,
  // filler pattern at all other times.
  localparam logic [DW-1:0] FILL = 24'hA5A5A5;

  function automatic logic [DW-1:0] mem(input logic [2:0] a);
    logic [7:0] b;
    b = {5'd0, a};
    return {b + 8'h20, b + 8'h10, b};
  endfunction

  logic [DW-1:0] pipe_a [2];
  logic [DW-1:0] pipe_b [4];
  always @(posedge clk) begin
    pipe_a[0] <= rd_en ? mem(adb) : FILL;
    pipe_a[1] <= pipe_a[0];
    pipe_b[0] <= rd_en2 ? mem(adb2) : FILL;
    for (int k = 1; k < 4; k++) pipe_b[k] <= pipe_b[k-1];
  end
  assign buf_dout  = pipe_a[1];
  assign buf_dout2 = pipe_b[3];

  // Event bookkeeping, updated on the active edge, read on the falling edge.
  int cyc = 0, rd_last = 0, rd_last2 = 0, rd_cnt = 0, swap_cnt = 0, swap_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) begin rd_last <= cyc; rd_cnt <= rd_cnt + 1; end
    if (rd_en2) rd_last2 <= cyc;
    if (buf_swap) begin swap_cnt <= swap_cnt + 1; swap_cyc <= cyc; end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int            stall;
    logic [DW-1:0] data;
    logic          img;
    logic          col;
  } vec_t;
  vec_t vecs [DEPTH];

  // Present one word: optional stall with out_ready low, then accept it.
  task automatic run_vec(input int i, input bit use_stall);
    int  st;
    int  good;
    bit  seen;
    st = use_stall ? vecs[i].stall : 0;
    out_ready = (st == 0);
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk($sformatf("valid_timeout[%0d]", i), 64'(seen), 64'd1);
    chk($sformatf("latency[%0d]", i), 64'(cyc - rd_last), 64'd3);
    if (st > 0) begin
      good = 0;
      for (int k = 0; k < st; k++) begin
        @(negedge clk);
        if (out_valid && out_data == vecs[i].data && !rd_en) good++;
      end
      chk($sformatf("bp_hold[%0d]", i), 64'(good), 64'(st));
      out_ready = 1'b1;
    end
    chk($sformatf("data[%0d]", i), 64'(out_data), 64'(vecs[i].data));
    chk($sformatf("new_image[%0d]", i), 64'(out_new_image), 64'(vecs[i].img));
    chk($sformatf("new_column[%0d]", i), 64'(out_new_column), 64'(vecs[i].col));
    chk($sformatf("adb[%0d]", i), 64'(adb), 64'(i));
    @(posedge clk); #1;
  endtask

  initial begin
    int bad;
    int base;
    int d;
    bit seen;

    // Expected words {addr+0x20, addr+0x10, addr}; word 3 is stalled 10 cycles.
    vecs[0] = '{0,  24'h201000, 1'b1, 1'b1};
    vecs[1] = '{0,  24'h211101, 1'b0, 1'b0};
    vecs[2] = '{0,  24'h221202, 1'b0, 1'b0};
    vecs[3] = '{10, 24'h231303, 1'b0, 1'b0};
    vecs[4] = '{0,  24'h241404, 1'b0, 1'b1};
    vecs[5] = '{0,  24'h251505, 1'b0, 1'b0};
    vecs[6] = '{0,  24'h261606, 1'b0, 1'b0};
    vecs[7] = '{0,  24'h271707, 1'b0, 1'b0};

    buf_valid = 0; out_ready = 0; tx_finish = 0;
    buf_valid2 = 0; out_ready2 = 0; tx_finish2 = 0;

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({buf_swap, rd_en, adb, out_data, out_valid,
        out_new_image, out_new_column, busy}), 64'd0);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ({buf_swap, rd_en, adb, out_data, out_valid, out_new_image,
           out_new_column, busy} != '0) bad++;
    end
    chk("idle_outputs_bad_cycles", 64'(bad), 64'd0);
    chk("idle_rd_en_count", 64'(rd_cnt), 64'd0);

    // Frame 1: full frame with backpressure on word 3, buf_valid dropped mid-frame
    tx_finish = 1'b1;
    buf_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("no_swap_before_last", 64'(swap_cnt), 64'd0);
      run_vec(i, 1'b1);
      if (i == 0) buf_valid = 1'b0;
    end
    out_ready = 1'b0;
    repeat (20) @(negedge clk);
    chk("frame1_swap_count", 64'(swap_cnt), 64'd1);
    chk("frame1_idle_busy", 64'(busy), 64'd0);

    // Frame 2: drain waits for tx_finish, guard ignores buf_valid
    tx_finish = 1'b0;
    buf_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) run_vec(i, 1'b0);
    out_ready = 1'b0;
    base = swap_cnt;
    repeat (15) @(negedge clk);
    chk("drain_no_swap", 64'(swap_cnt), 64'(base));
    chk("drain_busy", 64'(busy), 64'd1);
    tx_finish = 1'b1;
    d = cyc;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (swap_cnt != base) seen = 1;
    end
    chk("swap_seen", 64'(seen), 64'd1);
    chk("swap_delay", 64'(swap_cyc - d), 64'd1);
    tx_finish = 1'b0;
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (rd_en) seen = 1;
    end
    chk("guard_rd_seen", 64'(seen), 64'd1);
    // 4 guard cycles, 1 idle cycle, then fetch
    chk("guard_rd_spacing", 64'(cyc - swap_cyc), 64'd6);
    chk("guard_single_swap", 64'(swap_cnt), 64'(base + 1));

    // Frame 3: async reset while word 5 is presented
    for (int i = 0; i < 5; i++) run_vec(i, 1'b0);
    out_ready = 1'b0;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("w5_presented", 64'({seen, adb}), 64'({1'b1, 3'd5}));
    base = swap_cnt;
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_outputs", 64'({buf_swap, rd_en, adb, out_data, out_valid,
        out_new_image, out_new_column, busy}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midreset_no_swap", 64'(swap_cnt), 64'(base));
    run_vec(0, 1'b0);
    buf_valid = 1'b0;
    out_ready = 1'b0;

    // Latency with READ_LATENCY = 4
    buf_valid2 = 1'b1; out_ready2 = 1'b1; tx_finish2 = 1'b1;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (rd_en2) seen = 1;
    end
    chk("rl4_rd_seen", 64'(seen), 64'd1);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (out_valid2) seen = 1;
    end
    chk("rl4_valid_seen", 64'(seen), 64'd1);
    chk("rl4_latency", 64'(cyc - rd_last2), 64'd5);
    chk("rl4_data", 64'(out_data2), 64'h201000);
    chk("rl4_markers", 64'({out_new_image2, out_new_column2}), 64'b11);
    buf_valid2 = 1'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/buffer_frame_reader.md
Name: buffer_frame_reader

Overview:
Read-side sequencer for the Double_Buffer, running in the system `clk` domain. It waits for a filled bank and walks port B addresses 0..ADDRESS_DEPTH-1. Each word it reads is handed to the SPI Output_Module over a valid/ready handshake, tagged with new_image and new_column markers. After the frame is sent and transmission finishes, it pulses swap_trigger so the writer and reader banks exchange.

Parameters:
BANK_COUNT, 3, number of colour channels/banks (one SPI MOSI lane each)
ADDRESS_DEPTH, 480, words per bank per frame
WORD_WIDTH, 128, bits per bank word (BLOCK_COUNT*BLOCK_DATA_WIDTH)
WORDS_PER_COLUMN, 24, words forming one matrix column group; ADDRESS_DEPTH must be a multiple of it
READ_LATENCY, 2, clk cycles from rd_en to valid buf_dout (1..4)
GUARD_CYCLES, 4, idle cycles after a swap before buf_valid is sampled again

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
buf_valid  in  1  Double_Buffer data_valid: a complete frame is readable on port B
buf_swap  out  1  one-cycle swap_trigger pulse to the Double_Buffer
rd_en  out  1  port B read strobe (clk_data_out)
adb  out  $clog2(ADDRESS_DEPTH)  port B address
buf_dout  in  BANK_COUNT*WORD_WIDTH  port B data, bank 0 in LSBs
out_data  out  BANK_COUNT*WORD_WIDTH  registered word to Output_Module, same packing
out_valid  out  1  out_data valid
out_ready  in  1  Output_Module next_data; transfer when out_valid & out_ready
out_new_image  out  1  qualifies first word of frame (valid with out_valid)
out_new_column  out  1  qualifies first word of each column group, including word 0
tx_finish  in  1  Output_Module finished shifting last word (level)
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, adb=0, word and column counters 0, out_data=0. All 1-bit outputs are 0.
- IDLE: buf_valid=1 -> FETCH. Otherwise stay.
- FETCH: rd_en=1 for exactly one cycle with the current adb. Latency counter is loaded, then -> WAIT_RD.
- WAIT_RD: counts READ_LATENCY-1 further cycles. On the cycle buf_dout is valid (READ_LATENCY cycles after the rd_en cycle), capture out_data and markers, then -> PRESENT.
- Markers: out_new_image = (adb==0). out_new_column = (adb mod WORDS_PER_COLUMN == 0), tracked with a column counter (no divider).
- PRESENT: out_valid=1. out_data and markers are held stable until out_ready=1 is sampled. out_valid may not drop before acceptance. out_ready while out_valid=0 is ignored.
- On acceptance, out_valid=0 on the next cycle:
  - adb < ADDRESS_DEPTH-1: adb+1, -> FETCH.
  - adb == ADDRESS_DEPTH-1: adb=0, -> DRAIN.
- Single-word throughput: 1 FETCH + READ_LATENCY + 1 PRESENT cycle minimum; no prefetch.
- DRAIN: wait for tx_finish=1. A tx_finish high before the last acceptance is ignored; it is only sampled in DRAIN.
- SWAP: buf_swap=1 for exactly one cycle, -> GUARD.
- GUARD: wait GUARD_CYCLES, then -> IDLE. buf_valid is ignored during GUARD, so a stale level after the swap cannot restart a frame.
- buf_valid is sampled only in IDLE. Its deassertion mid-frame has no effect; the frame completes.
- Address wrap: adb never exceeds ADDRESS_DEPTH-1. The column counter resets at each frame start.
- Async reset mid-frame: immediate return to reset values, with no buf_swap pulse. The next frame starts at adb=0 with out_new_image=1.
- Width rules: counters are sized $clog2(max+1). No truncation of adb. out_data is a pure register copy with no byte reordering.

Test Plan:
Bench parameters: ADDRESS_DEPTH=8, WORDS_PER_COLUMN=4, READ_LATENCY=2, GUARD_CYCLES=4, BANK_COUNT=3, WORD_WIDTH=8, and a memory model returning buf_dout = {addr+0x20, addr+0x10, addr}.
- Reset/idle: rst_n=0, then 1, buf_valid=0 for 20 cycles -> all outputs stay 0, busy=0, rd_en never asserts.
- Full frame: buf_valid=1, out_ready=1 constant, tx_finish=1 -> 8 transfers with out_data 0x201000..0x271707 in order. out_new_image only on word 0; out_new_column on words 0 and 4. Exactly one buf_swap pulse, after the 8th transfer.
- Backpressure: out_ready=0 for 10 cycles on word 3 -> out_valid stays 1, out_data holds 0x231303, no rd_en issued. Release -> word 4 follows with out_new_column=1.
- Latency: rd_en at cycle t -> out_valid first high at cycle t+3. Repeat with READ_LATENCY=4 -> t+5.
- Drain/guard: hold tx_finish=0 after word 7 for 15 cycles -> no buf_swap. tx_finish=1 -> buf_swap 1 cycle later. buf_valid held 1 -> next rd_en no earlier than 4 GUARD cycles after buf_swap.
- Reset mid-frame: assert rst_n=0 during word 5 PRESENT -> outputs clear immediately, no buf_swap. On restart, first word is addr 0 with out_new_image=1.
